// File: rtl/ex_mul64_seq_pkg.sv
// ex_mul64_seq_pkg
//   Shared definitions for the 64x64 multiply sequencer and its accumulator.
//   Contents: FSM state encoding, internal operation codes, a 64-bit zero
//   constant, and helpers for request decoding and partial-product operand
//   selection.
//   Configuration macro: EX_MUL64_SEQ_SIGNED_EN (when undefined, reqOp=10 is
//   decoded as the unsigned high operation).
package ex_mul64_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FIX   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_LO  = 2'b00,
    OP_HIU = 2'b01,
    OP_HIS = 2'b10
  } op_e;

  localparam logic [63:0] ZERO64 = 64'd0;

  // Map the raw reqOp field onto the operation actually executed.
  // Code 11 falls back to the low product.
  function automatic op_e decode_op(input logic [1:0] raw);
    op_e op;
    case (raw)
      2'b01:   op = OP_HIU;
`ifdef EX_MUL64_SEQ_SIGNED_EN
      2'b10:   op = OP_HIS;
`else
      2'b10:   op = OP_HIU;
`endif
      default: op = OP_LO;
    endcase
    return op;
  endfunction

  // Operand pair {a_half, b_half} for partial product k:
  // bit 1 of k selects the half of A, bit 0 selects the half of B.
  function automatic logic [63:0] pp_operands(input logic [1:0]  k,
                                              input logic [63:0] a,
                                              input logic [63:0] b);
    logic [31:0] a_half;
    logic [31:0] b_half;
    a_half = k[1] ? a[63:32] : a[31:0];
    b_half = k[0] ? b[63:32] : b[31:0];
    return {a_half, b_half};
  endfunction

endpackage

// File: rtl/ex_mul64_acc.sv
// ex_mul64_acc
//   128-bit shifted accumulator for the partial products of a 64x64 multiply,
//   plus the signed-high correction subtractor.
//   Ports:
//     clock, reset     clock and asynchronous active-low reset
//     clr              zero the accumulator (new operation accepted)
//     add_en, add_k    add add_prod at the offset implied by partial index k
//     add_prod         64-bit unsigned partial product
//     fix_en           apply signed correction to the high half
//                      (present only with EX_MUL64_SEQ_SIGNED_EN)
//     op_a, op_b       latched operands used by the correction
//                      (present only with EX_MUL64_SEQ_SIGNED_EN)
//     acc              current accumulator value
//   Configuration macro: EX_MUL64_SEQ_SIGNED_EN.
module ex_mul64_acc
  import ex_mul64_seq_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         add_en,
  input  logic [1:0]   add_k,
  input  logic [63:0]  add_prod,
`ifdef EX_MUL64_SEQ_SIGNED_EN
  input  logic         fix_en,
  input  logic [63:0]  op_a,
  input  logic [63:0]  op_b,
`endif
  output logic [127:0] acc
);

  logic [127:0] acc_q;
  logic [127:0] acc_d;
  logic [127:0] addend;
  logic [6:0]   shamt;
`ifdef EX_MUL64_SEQ_SIGNED_EN
  logic [63:0]  corr_a;
  logic [63:0]  corr_b;
`endif

  // Offsets: lo*lo at 0, the two cross terms at 32, hi*hi at 64.
  always_comb begin
    shamt = 7'd32;
    case (add_k)
      2'd0:    shamt = 7'd0;
      2'd3:    shamt = 7'd64;
      default: shamt = 7'd32;
    endcase
    addend = {ZERO64, add_prod} << shamt;
  end

`ifdef EX_MUL64_SEQ_SIGNED_EN
  // Unsigned product of the two's-complement bit patterns exceeds the signed
  // product by 2^64*(A[63]*B + B[63]*A) in the high half; remove those terms.
  assign corr_a = op_a[63] ? op_b : ZERO64;
  assign corr_b = op_b[63] ? op_a : ZERO64;
`endif

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + addend;
`ifdef EX_MUL64_SEQ_SIGNED_EN
    end else if (fix_en) begin
      acc_d = {acc_q[127:64] - corr_a - corr_b, acc_q[63:0]};
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/ex_mul64_seq.sv
// ex_mul64_seq
//   Sequencer for a 64x64 multiply built from up to four 32x32 unsigned
//   partial products issued into a shared pipelined multiplier.
//   Ports:
//     clock, reset            clock and asynchronous active-low reset
//     reqValid/reqReady       request handshake; reqRs=A, reqRt=B, reqOp=op
//     rspValid/rspReady       response handshake; rspData holds the result
//     mulRs, mulRt            operands to the shared 32-bit multiplier
//     mulUns, mulIssue        unsigned select and operand-valid strobe
//     mulRn                   product, MUL_LAT cycles after issue
//   Parameter MUL_LAT (>= 1): multiplier latency in cycles.
//   Configuration macro: EX_MUL64_SEQ_SIGNED_EN enables the signed-high
//   operation (FIX state); without it op 10 runs as unsigned high.
module ex_mul64_seq
  import ex_mul64_seq_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [63:0] reqRs,
  input  logic [63:0] reqRt,
  input  logic [1:0]  reqOp,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [63:0] rspData,
  output logic [31:0] mulRs,
  output logic [31:0] mulRt,
  output logic        mulUns,
  output logic        mulIssue,
  input  logic [63:0] mulRn
);

  state_e state_q, state_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  op_e         op_q, op_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] mul_rs_q, mul_rs_d;
  logic [31:0] mul_rt_q, mul_rt_d;
  logic        rdy_en_q, rdy_en_d;

  // Return tags: stage MUL_LAT-1 lines up with the product on mulRn.
  logic [MUL_LAT-1:0]       tag_vld_q, tag_vld_d;
  logic [MUL_LAT-1:0][1:0]  tag_k_q, tag_k_d;

  logic         accept;
  logic         issue;
  logic         ret_last;
  logic [1:0]   last_k;
  logic [1:0]   k_inc;
  logic [63:0]  nxt_ops;
  logic [127:0] acc;

  assign last_k   = (op_q == OP_LO) ? 2'd2 : 2'd3;
  assign accept   = reqValid && reqReady;
  assign issue    = (state_q == ST_ISSUE);
  assign k_inc    = k_q + 2'd1;
  assign nxt_ops  = pp_operands(k_inc, a_q, b_q);
  // Products return in issue order, so the last tag marks completion.
  assign ret_last = tag_vld_q[MUL_LAT-1] && (tag_k_q[MUL_LAT-1] == last_k);

  // ---------------- state register ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      a_q       <= ZERO64;
      b_q       <= ZERO64;
      op_q      <= OP_LO;
      k_q       <= 2'd0;
      mul_rs_q  <= 32'd0;
      mul_rt_q  <= 32'd0;
      rdy_en_q  <= 1'b0;
      tag_vld_q <= '0;
      tag_k_q   <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      k_q       <= k_d;
      mul_rs_q  <= mul_rs_d;
      mul_rt_q  <= mul_rt_d;
      rdy_en_q  <= rdy_en_d;
      tag_vld_q <= tag_vld_d;
      tag_k_q   <= tag_k_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: if (k_q == last_k) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (ret_last) begin
`ifdef EX_MUL64_SEQ_SIGNED_EN
          state_d = (op_q == OP_HIS) ? ST_FIX : ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef EX_MUL64_SEQ_SIGNED_EN
      ST_FIX:   state_d = ST_DONE;
`endif
      ST_DONE:  if (rspReady) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    k_d      = k_q;
    mul_rs_d = mul_rs_q;
    mul_rt_d = mul_rt_q;
    // Released from reset after the first clock edge; gates reqReady.
    rdy_en_d = 1'b1;

    if (accept) begin
      a_d      = reqRs;
      b_d      = reqRt;
      op_d     = decode_op(reqOp);
      k_d      = 2'd0;
      // Operands for k=0 are registered now so they are valid in the
      // first ISSUE cycle.
      mul_rs_d = reqRs[31:0];
      mul_rt_d = reqRt[31:0];
    end else if (issue && (k_q != last_k)) begin
      k_d      = k_inc;
      mul_rs_d = nxt_ops[63:32];
      mul_rt_d = nxt_ops[31:0];
    end

    tag_vld_d    = tag_vld_q;
    tag_k_d      = tag_k_q;
    tag_vld_d[0] = issue;
    tag_k_d[0]   = k_q;
    for (int i = 1; i < MUL_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_k_d[i]   = tag_k_q[i-1];
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    reqReady = (state_q == ST_IDLE) && rdy_en_q;
    rspValid = (state_q == ST_DONE);
    rspData  = ZERO64;
    if (state_q == ST_DONE) begin
      rspData = (op_q == OP_LO) ? acc[63:0] : acc[127:64];
    end
    mulIssue = issue;
    mulUns   = issue;
  end

  assign mulRs = mul_rs_q;
  assign mulRt = mul_rt_q;

  ex_mul64_acc u_acc (
    .clock    (clock),
    .reset    (reset),
    .clr      (accept),
    .add_en   (tag_vld_q[MUL_LAT-1]),
    .add_k    (tag_k_q[MUL_LAT-1]),
    .add_prod (mulRn),
`ifdef EX_MUL64_SEQ_SIGNED_EN
    .fix_en   (state_q == ST_FIX),
    .op_a     (a_q),
    .op_b     (b_q),
`endif
    .acc      (acc)
  );

endmodule

// File: tb/tb_ex_mul64_seq.sv
// tb_ex_mul64_seq
//   Self-checking bench for ex_mul64_seq: a behavioural 128-bit multiply model
//   produces expected results, a driver pushes them into a scoreboard queue,
//   and a monitor pops and compares whenever a response first appears.
//   A pipelined multiplier model sits on the mul* ports.
//   Honours EX_MUL64_SEQ_SIGNED_EN like the design.
module tb_ex_mul64_seq;

  localparam int MUL_LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [63:0] reqRs = '0;
  logic [63:0] reqRt = '0;
  logic [1:0]  reqOp = '0;
  logic        rspValid;
  logic        rspReady = 1'b1;
  logic [63:0] rspData;
  logic [31:0] mulRs;
  logic [31:0] mulRt;
  logic        mulUns;
  logic        mulIssue;
  logic [63:0] mulRn;

  ex_mul64_seq #(.MUL_LAT(MUL_LAT)) dut (
    .clock    (clock),
    .reset    (reset),
    .reqValid (reqValid),
    .reqReady (reqReady),
    .reqRs    (reqRs),
    .reqRt    (reqRt),
    .reqOp    (reqOp),
    .rspValid (rspValid),
    .rspReady (rspReady),
    .rspData  (rspData),
    .mulRs    (mulRs),
    .mulRt    (mulRt),
    .mulUns   (mulUns),
    .mulIssue (mulIssue),
    .mulRn    (mulRn)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // Multiplier model: garbage on idle cycles so untagged returns would show.
  logic [63:0] mp [MUL_LAT];
  always @(posedge clock) begin
    mp[0] <= mulIssue ? ({32'd0, mulRs} * {32'd0, mulRt}) : {$urandom, $urandom};
    for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
  end
  assign mulRn = mp[MUL_LAT-1];

  typedef struct {
    logic [63:0] data;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_cyc_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_rsp    = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] op);
    logic [127:0]        pu;
    logic signed [127:0] ps;
    pu = {64'd0, a} * {64'd0, b};
    ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    case (op)
      2'b01: return pu[127:64];
`ifdef EX_MUL64_SEQ_SIGNED_EN
      2'b10: return ps[127:64];
`else
      2'b10: return pu[127:64];
`endif
      default: return pu[63:0];
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
    case (op)
      2'b01: return 7;
`ifdef EX_MUL64_SEQ_SIGNED_EN
      2'b10: return 8;
`else
      2'b10: return 7;
`endif
      default: return 6;
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic        prev_vld = 1'b0;
  logic [63:0] held;
  always @(negedge clock) begin
    if (!reset) begin
      prev_vld = 1'b0;
    end else begin
      if (reqValid && reqReady) acc_cyc_q.push_back(cyc);
      if (mulIssue) check64("mul_uns", {63'd0, mulUns}, 64'd1);
      if (rspValid && !prev_vld) begin
        if (exp_q.size() == 0 || acc_cyc_q.size() == 0) begin
          check64("unexpected_rsp", {63'd0, rspValid}, 64'd0);
        end else begin
          exp_t e;
          int   ac;
          e  = exp_q.pop_front();
          ac = acc_cyc_q.pop_front();
          n_rsp++;
          $display("rsp %0d: data=%h expected=%h latency=%0d", n_rsp, rspData, e.data, cyc - ac);
          check64("rsp_data", rspData, e.data);
          check64("rsp_latency", 64'(cyc - ac), 64'(e.lat));
        end
        held = rspData;
      end else if (rspValid && prev_vld) begin
        check64("hold_data", rspData, held);
        check64("hold_ready", {63'd0, reqReady}, 64'd0);
      end
      prev_vld = rspValid;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ready();
    int n = 0;
    while (reqReady !== 1'b1 && n < 50) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 50) check64("ready_timeout", {63'd0, reqReady}, 64'd1);
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] op, input int hold);
    exp_t e;
    int   n;
    wait_ready();
    e.data = ref_mul(a, b, op);
    e.lat  = exp_lat(op);
    exp_q.push_back(e);
    reqRs    = a;
    reqRt    = b;
    reqOp    = op;
    reqValid = 1'b1;
    rspReady = (hold == 0);
    @(posedge clock); #1;
    reqValid = 1'b0;
    reqRs    = {$urandom, $urandom};
    reqRt    = {$urandom, $urandom};
    reqOp    = 2'($urandom);
    n = 0;
    while (rspValid !== 1'b1 && n < 50) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 50) check64("rsp_timeout", {63'd0, rspValid}, 64'd1);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clock); #1;
      end
      rspReady = 1'b1;
    end
    @(posedge clock); #1;
    check64("ready_after_rsp", {63'd0, reqReady}, 64'd1);
    check64("valid_after_rsp", {63'd0, rspValid}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check64({tag, "_reqReady"}, {63'd0, reqReady}, 64'd0);
    check64({tag, "_rspValid"}, {63'd0, rspValid}, 64'd0);
    check64({tag, "_rspData"},  rspData, 64'd0);
    check64({tag, "_mulIssue"}, {63'd0, mulIssue}, 64'd0);
    check64({tag, "_mulUns"},   {63'd0, mulUns}, 64'd0);
    check64({tag, "_mulRsRt"},  {mulRs, mulRt}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check64("ready_after_reset", {63'd0, reqReady}, 64'd1);

    // Directed cases
    run_op(64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 2'b00, 0);
    run_op(64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 2'b01, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 0);
    run_op(-64'sd2, 64'd3, 2'b10, 0);
    run_op(-64'sd2, 64'd3, 2'b00, 0);
    run_op(-64'sd2, 64'd3, 2'b11, 0);

    // Backpressure: response held for 5 extra cycles
    run_op(-64'sd2, 64'd3, 2'b00, 5);

    // Reset during the second ISSUE cycle
    wait_ready();
    reqRs    = {$urandom, $urandom};
    reqRt    = {$urandom, $urandom};
    reqOp    = 2'b01;
    reqValid = 1'b1;
    @(posedge clock); #1;
    reqValid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    acc_cyc_q.delete();
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("midreset_held");
    reset = 1'b1;
    run_op(64'd3, 64'd5, 2'b00, 0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [63:0] a;
      logic [63:0] b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ((i % 8) == 3) a[63:32] = 32'hFFFF_FFFF;
      if ((i % 8) == 5) b[31:0]  = 32'd0;
      run_op(a, b, 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    repeat (4) @(posedge clock);
    #1;
    check64("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
